// File: rtl/latch_seq_pkg.sv
// Shared types and helpers for the latch-bank write sequencer.
package latch_seq_pkg;

  // Widest latch bank the one-hot decoder can address.
  localparam int unsigned MAX_DEPTH = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // Bits needed to hold the largest phase length; never less than one.
  function automatic int unsigned cnt_width(input int unsigned setup_cyc,
                                            input int unsigned pulse_cyc,
                                            input int unsigned hold_cyc);
    int unsigned m;
    m = setup_cyc;
    if (pulse_cyc > m) m = pulse_cyc;
    if (hold_cyc > m) m = hold_cyc;
    if (m < 1) return 1;
    return $clog2(m + 1);
  endfunction

  // One-hot decode of an index into a MAX_DEPTH-wide vector.
  function automatic logic [MAX_DEPTH-1:0] onehot(input int unsigned idx);
    logic [MAX_DEPTH-1:0] v;
    v = '0;
    if (idx < MAX_DEPTH) v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/latch_wr_timer.sv
// Loadable down-counter that times each sequencer phase.
module latch_wr_timer #(
  parameter int unsigned CW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          zero_c
);

  logic [CW-1:0] cnt_q;

  // Load on phase entry, otherwise count down and rest at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/latch_bank_wr_seq.sv
// Write-side sequencer driving E/D pins of a bank of transparent-high latches.
// Every accepted write runs setup (D stable, E low), pulse (one E high) and
// hold (D stable, E low) phases; E and D come straight from flops.
module latch_bank_wr_seq #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned AW        = 2,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             wr_valid,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic [DEPTH-1:0] lat_e,
  output logic [WIDTH-1:0] lat_d,
  output logic             wr_done,
  output logic             wr_err
);

  import latch_seq_pkg::*;

  localparam int unsigned CW = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);

  // Reject illegal parameter sets at elaboration.
  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth_range
    $error("latch_bank_wr_seq: DEPTH must be in 1..%0d", MAX_DEPTH);
  end
  if (64'(DEPTH) > (64'(1) << AW)) begin : g_bad_depth_aw
    $error("latch_bank_wr_seq: DEPTH exceeds 2**AW");
  end
  if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_bad_cyc
    $error("latch_bank_wr_seq: SETUP_CYC, PULSE_CYC and HOLD_CYC must be >= 1");
  end

  state_e           state_q, state_nxt;
  logic [AW-1:0]    addr_q, addr_nxt;
  logic [DEPTH-1:0] lat_e_q, lat_e_nxt;
  logic [WIDTH-1:0] lat_d_q, lat_d_nxt;
  logic             done_q, done_nxt;
  logic             err_q, err_nxt;

  logic             tmr_load_c;
  logic [CW-1:0]    tmr_val_c;
  logic             tmr_zero_c;
  logic             accept_c;
  logic             in_range_c;

  latch_wr_timer #(
    .CW (CW)
  ) u_timer (
    .clk      (CLK),
    .rst_n    (RN),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .zero_c   (tmr_zero_c)
  );

  // Ready only from IDLE and never while reset is asserted.
  assign wr_ready   = RN & (state_q == IDLE);
  assign accept_c   = wr_valid & wr_ready;
  assign in_range_c = ({1'b0, wr_addr} < (AW+1)'(DEPTH));

  // Next-state, timer-load and next-output decode.
  always_comb begin
    state_nxt  = state_q;
    addr_nxt   = addr_q;
    lat_e_nxt  = '0;
    lat_d_nxt  = lat_d_q;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (in_range_c) begin
            addr_nxt   = wr_addr;
            lat_d_nxt  = wr_data;
            state_nxt  = SETUP;
            tmr_load_c = 1'b1;
            tmr_val_c  = CW'(SETUP_CYC - 1);
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      SETUP: begin
        if (tmr_zero_c) begin
          state_nxt  = PULSE;
          tmr_load_c = 1'b1;
          tmr_val_c  = CW'(PULSE_CYC - 1);
          lat_e_nxt  = DEPTH'(onehot(32'(addr_q)));
        end
      end
      PULSE: begin
        if (tmr_zero_c) begin
          state_nxt  = HOLD;
          tmr_load_c = 1'b1;
          tmr_val_c  = CW'(HOLD_CYC - 1);
        end else begin
          lat_e_nxt = lat_e_q;
        end
      end
      HOLD: begin
        if (tmr_zero_c) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset drops the enables asynchronously.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lat_e_q <= '0;
      lat_d_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      addr_q  <= addr_nxt;
      lat_e_q <= lat_e_nxt;
      lat_d_q <= lat_d_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
    end
  end

  assign lat_e   = lat_e_q;
  assign lat_d   = lat_d_q;
  assign wr_done = done_q;
  assign wr_err  = err_q;

endmodule

// File: tb/tb_latch_bank_wr_seq.sv
// Directed bench for latch_bank_wr_seq: a per-cycle vector table on the
// default configuration plus short sequences for range error, long phases
// and reset during a pulse.
module tb_latch_bank_wr_seq;

  logic       clk;
  logic       rn;
  logic       wr_valid;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;

  // Default configuration
  logic       a_ready, a_done, a_err;
  logic [3:0] a_e;
  logic [7:0] a_d;
  // DEPTH=3
  logic       b_ready, b_done, b_err;
  logic [2:0] b_e;
  logic [7:0] b_d;
  // SETUP=3, PULSE=1, HOLD=2
  logic       c_ready, c_done, c_err;
  logic [3:0] c_e;
  logic [7:0] c_d;

  int checks = 0;
  int errors = 0;

  latch_bank_wr_seq u_dut (
    .CLK (clk), .RN (rn), .wr_valid (wr_valid), .wr_addr (wr_addr),
    .wr_data (wr_data), .wr_ready (a_ready), .lat_e (a_e), .lat_d (a_d),
    .wr_done (a_done), .wr_err (a_err)
  );

  latch_bank_wr_seq #(.DEPTH(3)) u_d3 (
    .CLK (clk), .RN (rn), .wr_valid (wr_valid), .wr_addr (wr_addr),
    .wr_data (wr_data), .wr_ready (b_ready), .lat_e (b_e), .lat_d (b_d),
    .wr_done (b_done), .wr_err (b_err)
  );

  latch_bank_wr_seq #(.SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) u_long (
    .CLK (clk), .RN (rn), .wr_valid (wr_valid), .wr_addr (wr_addr),
    .wr_data (wr_data), .wr_ready (c_ready), .lat_e (c_e), .lat_d (c_d),
    .wr_done (c_done), .wr_err (c_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] a;
    logic [7:0] d;
    logic       rdy;
    logic [3:0] e;
    logic [7:0] q;
    logic       done;
    logic       err;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic v, input logic [1:0] a, input logic [7:0] d,
                              input logic rdy, input logic [3:0] e, input logic [7:0] q,
                              input logic done, input logic err);
    vec_t r;
    r.v = v; r.a = a; r.d = d; r.rdy = rdy; r.e = e; r.q = q; r.done = done; r.err = err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] a, input logic [7:0] d);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 2'd0, 8'h00);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Each row: outputs expected in this cycle, inputs presented for the next edge.
    vecs[0]  = mk(1, 2, 8'hA5, 1, 4'b0000, 8'h00, 0, 0);
    vecs[1]  = mk(0, 0, 8'h00, 0, 4'b0000, 8'hA5, 0, 0);
    vecs[2]  = mk(0, 0, 8'h00, 0, 4'b0100, 8'hA5, 0, 0);
    vecs[3]  = mk(0, 0, 8'h00, 0, 4'b0100, 8'hA5, 0, 0);
    vecs[4]  = mk(0, 0, 8'h00, 0, 4'b0000, 8'hA5, 0, 0);
    vecs[5]  = mk(0, 0, 8'h00, 1, 4'b0000, 8'hA5, 1, 0);
    vecs[6]  = mk(1, 1, 8'h3C, 1, 4'b0000, 8'hA5, 0, 0);
    vecs[7]  = mk(1, 3, 8'hC3, 0, 4'b0000, 8'h3C, 0, 0);
    vecs[8]  = mk(0, 0, 8'h00, 0, 4'b0010, 8'h3C, 0, 0);
    vecs[9]  = mk(1, 0, 8'h55, 0, 4'b0010, 8'h3C, 0, 0);
    vecs[10] = mk(0, 0, 8'h00, 0, 4'b0000, 8'h3C, 0, 0);
    vecs[11] = mk(1, 3, 8'hC3, 1, 4'b0000, 8'h3C, 1, 0);
    vecs[12] = mk(0, 0, 8'h00, 0, 4'b0000, 8'hC3, 0, 0);
    vecs[13] = mk(0, 0, 8'h00, 0, 4'b1000, 8'hC3, 0, 0);
    vecs[14] = mk(0, 0, 8'h00, 0, 4'b1000, 8'hC3, 0, 0);
    vecs[15] = mk(0, 0, 8'h00, 0, 4'b0000, 8'hC3, 0, 0);
    vecs[16] = mk(0, 0, 8'h00, 1, 4'b0000, 8'hC3, 1, 0);
    vecs[17] = mk(0, 0, 8'h00, 1, 4'b0000, 8'hC3, 0, 0);

    // Reset state
    rn = 1'b0;
    drive(1'b0, 2'd0, 8'h00);
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_lat_e", 32'(a_e), 32'd0);
    chk("rst_lat_d", 32'(a_d), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    rn = 1'b1;
    @(negedge clk);

    // Single write, back-to-back write, requests ignored while busy
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("vec%0d_ready", i), 32'(a_ready), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d_lat_e", i), 32'(a_e), 32'(vecs[i].e));
      chk($sformatf("vec%0d_lat_d", i), 32'(a_d), 32'(vecs[i].q));
      chk($sformatf("vec%0d_done", i), 32'(a_done), 32'(vecs[i].done));
      chk($sformatf("vec%0d_err", i), 32'(a_err), 32'(vecs[i].err));
      drive(vecs[i].v, vecs[i].a, vecs[i].d);
      @(negedge clk);
    end

    // Out-of-range address on DEPTH=3 instance
    idle(8);
    drive(1'b1, 2'd0, 8'h5A);
    @(negedge clk);
    idle(8);
    chk("d3_pre_lat_d", 32'(b_d), 32'h5A);
    chk("d3_pre_ready", 32'(b_ready), 32'd1);
    drive(1'b1, 2'd3, 8'h77);
    @(negedge clk);
    drive(1'b0, 2'd0, 8'h00);
    chk("d3_err", 32'(b_err), 32'd1);
    chk("d3_err_lat_e", 32'(b_e), 32'd0);
    chk("d3_err_lat_d", 32'(b_d), 32'h5A);
    chk("d3_err_ready", 32'(b_ready), 32'd1);
    chk("d3_err_done", 32'(b_done), 32'd0);
    @(negedge clk);
    chk("d3_err_cleared", 32'(b_err), 32'd0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("d3_no_done_c%0d", k), 32'(b_done), 32'd0);
      chk($sformatf("d3_no_e_c%0d", k), 32'(b_e), 32'd0);
      @(negedge clk);
    end

    // Long setup/hold instance: 3 setup, 1 pulse, 2 hold, done at cycle 7
    idle(8);
    chk("long_ready0", 32'(c_ready), 32'd1);
    drive(1'b1, 2'd0, 8'hFF);
    @(negedge clk);
    drive(1'b0, 2'd0, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("long_lat_e_c%0d", k), 32'(c_e), (k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("long_lat_d_c%0d", k), 32'(c_d), 32'hFF);
      chk($sformatf("long_done_c%0d", k), 32'(c_done), (k == 7) ? 32'd1 : 32'd0);
      chk($sformatf("long_ready_c%0d", k), 32'(c_ready), (k >= 7) ? 32'd1 : 32'd0);
      chk($sformatf("long_err_c%0d", k), 32'(c_err), 32'd0);
      @(negedge clk);
    end

    // Reset asserted mid-pulse on the default instance
    idle(8);
    drive(1'b1, 2'd0, 8'h99);
    @(negedge clk);
    drive(1'b0, 2'd0, 8'h00);
    @(negedge clk);
    chk("rstmid_pulse_e", 32'(a_e), 32'b0001);
    chk("rstmid_pulse_d", 32'(a_d), 32'h99);
    #2 rn = 1'b0;
    #1;
    chk("rstmid_async_e", 32'(a_e), 32'd0);
    chk("rstmid_async_d", 32'(a_d), 32'd0);
    chk("rstmid_async_ready", 32'(a_ready), 32'd0);
    @(negedge clk);
    chk("rstmid_held_e", 32'(a_e), 32'd0);
    chk("rstmid_held_ready", 32'(a_ready), 32'd0);
    rn = 1'b1;
    @(negedge clk);
    chk("rstmid_rel_ready", 32'(a_ready), 32'd1);
    chk("rstmid_rel_e", 32'(a_e), 32'd0);
    chk("rstmid_rel_d", 32'(a_d), 32'd0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rstmid_no_done_c%0d", k), 32'(a_done), 32'd0);
      chk($sformatf("rstmid_no_e_c%0d", k), 32'(a_e), 32'd0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
